// File: rtl/sa_load_sequencer.sv
// sa_load_sequencer
// Sequences one tile job into a systolic array. A job optionally loads N
// weight rows, then always loads N input rows, each input row carrying its
// partial-sum row. Every accepted row is first captured into a staging
// register. It then appears on the array load strobes one cycle later, so
// all array-facing outputs come straight from flops.
//
// Row indices never reach N. The row counter returns to zero only when the
// state that owns it is left. A stalled upstream (row_valid low) freezes the
// counter and produces no strobe.

module sa_load_sequencer #(
    parameter int N          = 4,
    parameter int DW         = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  cmd_valid,
    input  logic                  cmd_new_weights,
    output logic                  cmd_ready,
    input  logic                  row_valid,
    input  logic [N*DW-1:0]       row_data,
    input  logic [N*DW-1:0]       row_partial,
    output logic                  row_ready,
    input  logic                  drained,
    input  logic                  fifo_has_space,
    output logic                  weight_en,
    output logic                  input_en,
    output logic                  partial_en,
    output logic [$clog2(N)-1:0]  row_in_en,
    output logic [$clog2(N)-1:0]  row_ps_en,
    output logic [N*DW-1:0]       array_in,
    output logic [N*DW-1:0]       array_in_partials,
    output logic                  busy,
    output logic                  done
);

    localparam int RW = N * DW;
    localparam int IW = $clog2(N);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [RW-1:0] ROW_ZERO  = {RW{1'b0}};
    localparam logic [GW-1:0] GAP_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DRAIN = 3'd1,
        ST_LOAD_W     = 3'd2,
        ST_WAIT_SPACE = 3'd3,
        ST_LOAD_IN    = 3'd4,
        ST_GAP        = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   count_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            last_row_r;

    // Staging stage: what was accepted on the previous edge.
    logic            cap_w_r;
    logic            cap_in_r;
    logic [IW-1:0]   cap_idx_r;
    logic [RW-1:0]   cap_data_r;
    logic [RW-1:0]   cap_part_r;

    // Output stage driving the array.
    logic            weight_en_r;
    logic            input_en_r;
    logic            partial_en_r;
    logic [IW-1:0]   row_in_en_r;
    logic [IW-1:0]   row_ps_en_r;
    logic [RW-1:0]   array_in_r;
    logic [RW-1:0]   array_in_partials_r;

    logic            row_ready_s;
    logic            idx_last_s;

    assign row_ready_s = (state_r == ST_LOAD_W) || (state_r == ST_LOAD_IN);
    assign idx_last_s  = (count_r == IDX_LAST);

    assign row_ready         = row_ready_s;
    assign cmd_ready         = (state_r == ST_IDLE);
    assign busy              = (state_r != ST_IDLE);
    assign done              = (state_r == ST_DONE);
    assign weight_en         = weight_en_r;
    assign input_en          = input_en_r;
    assign partial_en        = partial_en_r;
    assign row_in_en         = row_in_en_r;
    assign row_ps_en         = row_ps_en_r;
    assign array_in          = array_in_r;
    assign array_in_partials = array_in_partials_r;

    // Job state machine; also captures each accepted row into the staging stage.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            count_r    <= IDX_ZERO;
            gap_cnt_r  <= GAP_ZERO;
            last_row_r <= 1'b0;
            cap_w_r    <= 1'b0;
            cap_in_r   <= 1'b0;
            cap_idx_r  <= IDX_ZERO;
            cap_data_r <= ROW_ZERO;
            cap_part_r <= ROW_ZERO;
        end else begin
            // Staging defaults to empty so idle cycles present all-zero payloads.
            cap_w_r    <= 1'b0;
            cap_in_r   <= 1'b0;
            cap_idx_r  <= IDX_ZERO;
            cap_data_r <= ROW_ZERO;
            cap_part_r <= ROW_ZERO;

            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        count_r    <= IDX_ZERO;
                        last_row_r <= 1'b0;
                        state_r    <= cmd_new_weights ? ST_WAIT_DRAIN : ST_WAIT_SPACE;
                    end
                end

                ST_WAIT_DRAIN: begin
                    if (drained) begin
                        count_r <= IDX_ZERO;
                        state_r <= ST_LOAD_W;
                    end
                end

                ST_LOAD_W: begin
                    if (row_valid) begin
                        cap_w_r    <= 1'b1;
                        cap_idx_r  <= count_r;
                        cap_data_r <= row_data;
                        if (idx_last_s) begin
                            // Weights are followed directly by inputs; space is not rechecked.
                            count_r <= IDX_ZERO;
                            state_r <= ST_LOAD_IN;
                        end else begin
                            count_r <= count_r + IDX_ONE;
                        end
                    end
                end

                ST_WAIT_SPACE: begin
                    if (fifo_has_space) begin
                        count_r <= IDX_ZERO;
                        state_r <= ST_LOAD_IN;
                    end
                end

                ST_LOAD_IN: begin
                    if (row_valid) begin
                        cap_in_r   <= 1'b1;
                        cap_idx_r  <= count_r;
                        cap_data_r <= row_data;
                        cap_part_r <= row_partial;
                        last_row_r <= idx_last_s;
                        count_r    <= idx_last_s ? IDX_ZERO : (count_r + IDX_ONE);
                        if (GAP_CYCLES == 0) begin
                            state_r <= idx_last_s ? ST_DONE : ST_LOAD_IN;
                        end else begin
                            gap_cnt_r <= GAP_LOAD;
                            state_r   <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_r == GAP_ZERO) begin
                        state_r <= last_row_r ? ST_DONE : ST_LOAD_IN;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end
                end

                ST_DONE: begin
                    last_row_r <= 1'b0;
                    count_r    <= IDX_ZERO;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    count_r    <= IDX_ZERO;
                    gap_cnt_r  <= GAP_ZERO;
                    last_row_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stage: presents the staged row to the array for exactly one cycle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            weight_en_r         <= 1'b0;
            input_en_r          <= 1'b0;
            partial_en_r        <= 1'b0;
            row_in_en_r         <= IDX_ZERO;
            row_ps_en_r         <= IDX_ZERO;
            array_in_r          <= ROW_ZERO;
            array_in_partials_r <= ROW_ZERO;
        end else begin
            weight_en_r         <= cap_w_r;
            input_en_r          <= cap_in_r;
            partial_en_r        <= cap_in_r;
            row_in_en_r         <= cap_idx_r;
            row_ps_en_r         <= cap_in_r ? cap_idx_r : IDX_ZERO;
            array_in_r          <= cap_data_r;
            array_in_partials_r <= cap_part_r;
        end
    end

endmodule

// File: tb/tb_sa_load_sequencer.sv
// Bench for sa_load_sequencer: one instance with a single gap cycle, one with
// no gap. Expected array loads are queued as rows are issued; a monitor pops
// and compares them whenever a load strobe appears.

module tb_sa_load_sequencer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int RW = N * DW;
    localparam int IW = 2;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic nRST;

    logic          cmd_valid, cmd_new_weights, cmd_ready;
    logic          row_valid, row_ready, drained, fifo_has_space;
    logic [RW-1:0] row_data, row_partial, array_in, array_in_partials;
    logic          weight_en, input_en, partial_en, busy, done;
    logic [IW-1:0] row_in_en, row_ps_en;

    logic          g0_cmd_valid, g0_cmd_new_weights, g0_cmd_ready;
    logic          g0_row_valid, g0_row_ready, g0_drained, g0_fifo_has_space;
    logic [RW-1:0] g0_row_data, g0_row_partial, g0_array_in, g0_array_in_partials;
    logic          g0_weight_en, g0_input_en, g0_partial_en, g0_busy, g0_done;
    logic [IW-1:0] g0_row_in_en, g0_row_ps_en;

    sa_load_sequencer #(.N(N), .DW(DW), .GAP_CYCLES(1)) dut (
        .clk(tb_clk), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_new_weights(cmd_new_weights), .cmd_ready(cmd_ready),
        .row_valid(row_valid), .row_data(row_data), .row_partial(row_partial), .row_ready(row_ready),
        .drained(drained), .fifo_has_space(fifo_has_space),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .busy(busy), .done(done)
    );

    sa_load_sequencer #(.N(N), .DW(DW), .GAP_CYCLES(0)) dut_g0 (
        .clk(tb_clk), .nRST(nRST),
        .cmd_valid(g0_cmd_valid), .cmd_new_weights(g0_cmd_new_weights), .cmd_ready(g0_cmd_ready),
        .row_valid(g0_row_valid), .row_data(g0_row_data), .row_partial(g0_row_partial), .row_ready(g0_row_ready),
        .drained(g0_drained), .fifo_has_space(g0_fifo_has_space),
        .weight_en(g0_weight_en), .input_en(g0_input_en), .partial_en(g0_partial_en),
        .row_in_en(g0_row_in_en), .row_ps_en(g0_row_ps_en),
        .array_in(g0_array_in), .array_in_partials(g0_array_in_partials),
        .busy(g0_busy), .done(g0_done)
    );

    typedef struct {
        logic          w;
        logic [IW-1:0] idx;
        logic [RW-1:0] d;
        logic [RW-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp0_q[$];
    int   strobe_cyc[$];
    int   strobe0_cyc[$];
    int   done_cyc[$];
    int   done0_cyc[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   bad_rdy = 0;
    exp_t mon_e;
    exp_t mon0_e;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] pat(input int tag);
        logic [RW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = 16'(tag * 16 + j);
        return v;
    endfunction

    task automatic expect_row(input logic w, input int idx, input logic [RW-1:0] d, input logic [RW-1:0] p);
        exp_t e;
        e.w = w; e.idx = IW'(idx); e.d = d; e.p = p;
        exp_q.push_back(e);
    endtask

    // Monitor for the GAP_CYCLES=1 instance.
    always @(negedge tb_clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (cmd_ready && busy) bad_rdy++;
        if (done) done_cyc.push_back(cyc);
        if (weight_en || input_en) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {weight_en, input_en, row_in_en}, 4'b0000);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", {weight_en, input_en, partial_en}, {mon_e.w, ~mon_e.w, ~mon_e.w});
                check("row_in_en", row_in_en, mon_e.idx);
                check("row_ps_en", row_ps_en, mon_e.w ? 2'b00 : mon_e.idx);
                check("array_in", array_in, mon_e.d);
                check("array_in_partials", array_in_partials, mon_e.w ? {RW{1'b0}} : mon_e.p);
            end
        end else begin
            check("idle_outputs", {partial_en, row_in_en, row_ps_en, array_in, array_in_partials}, 256'd0);
        end
    end

    // Monitor for the GAP_CYCLES=0 instance.
    always @(negedge tb_clk) begin
        if (g0_done) done0_cyc.push_back(cyc);
        if (g0_weight_en || g0_input_en) begin
            strobe0_cyc.push_back(cyc);
            if (exp0_q.size() == 0) begin
                check("g0_unexpected_strobe", {g0_weight_en, g0_input_en, g0_row_in_en}, 4'b0000);
            end else begin
                mon0_e = exp0_q.pop_front();
                check("g0_strobe_kind", {g0_weight_en, g0_input_en, g0_partial_en}, {mon0_e.w, ~mon0_e.w, ~mon0_e.w});
                check("g0_row_in_en", g0_row_in_en, mon0_e.idx);
                check("g0_row_ps_en", g0_row_ps_en, mon0_e.idx);
                check("g0_array_in", g0_array_in, mon0_e.d);
                check("g0_array_in_partials", g0_array_in_partials, mon0_e.p);
            end
        end
    end

    task automatic issue_cmd(input logic nw);
        int t = 0;
        @(negedge tb_clk);
        while (!cmd_ready && t < 50) begin @(negedge tb_clk); t++; end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_new_weights = nw;
        @(negedge tb_clk);
        cmd_valid = 1'b0; cmd_new_weights = 1'b0;
    endtask

    task automatic send_row(input logic [RW-1:0] d, input logic [RW-1:0] p, input int stall);
        int t = 0;
        repeat (stall) begin @(negedge tb_clk); row_valid = 1'b0; end
        @(negedge tb_clk);
        row_valid = 1'b1; row_data = d; row_partial = p;
        while (!row_ready && t < 100) begin @(negedge tb_clk); t++; end
        check("row_ready_wait", row_ready, 1'b1);
        @(posedge tb_clk);
        #1;
    endtask

    task automatic end_rows();
        @(negedge tb_clk);
        row_valid = 1'b0;
    endtask

    task automatic check_diffs(input string name, input bit use0, input int n, input int d[8]);
        int sz;
        sz = use0 ? strobe0_cyc.size() : strobe_cyc.size();
        check({name, "_count"}, sz, n + 1);
        for (int i = 0; i < n && i + 1 < sz; i++) begin
            int a;
            a = use0 ? (strobe0_cyc[i+1] - strobe0_cyc[i]) : (strobe_cyc[i+1] - strobe_cyc[i]);
            check($sformatf("%s_spacing%0d", name, i), a, d[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        cmd_valid = 1'b0; cmd_new_weights = 1'b0; row_valid = 1'b0;
        row_data = '0; row_partial = '0; drained = 1'b1; fifo_has_space = 1'b1;
        g0_cmd_valid = 1'b0; g0_cmd_new_weights = 1'b0; g0_row_valid = 1'b0;
        g0_row_data = '0; g0_row_partial = '0; g0_drained = 1'b1; g0_fifo_has_space = 1'b1;
        nRST = 1'b1;
        #1 nRST = 1'b0;

        // Reset state
        repeat (2) @(negedge tb_clk);
        check("reset_busy", busy, 1'b0);
        check("reset_strobes", {weight_en, input_en, partial_en, done, row_ready}, 5'b00000);
        nRST = 1'b1;
        @(negedge tb_clk);
        check("release_cmd_ready", cmd_ready, 1'b1);
        check("release_busy", busy, 1'b0);

        // Weights + inputs, rows always valid
        strobe_cyc.delete(); done_cyc.delete();
        for (int r = 0; r < N; r++) expect_row(1'b1, r, pat(16'h01 + r), '0);
        for (int r = 0; r < N; r++) expect_row(1'b0, r, pat(16'h11 + r), pat(16'h21 + r));
        issue_cmd(1'b1);
        for (int r = 0; r < N; r++) send_row(pat(16'h01 + r), pat(16'h31 + r), 0);
        for (int r = 0; r < N; r++) send_row(pat(16'h11 + r), pat(16'h21 + r), 0);
        end_rows();
        repeat (6) @(negedge tb_clk);
        check_diffs("weights_job", 1'b0, 7, '{1, 1, 1, 1, 2, 2, 2, 0});
        check("weights_job_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && strobe_cyc.size() == 8)
            check("weights_job_done_cycle", done_cyc[0], strobe_cyc[7]);
        check("weights_job_queue_empty", exp_q.size(), 0);
        check("weights_job_idle", busy, 1'b0);

        // Inputs-only job held off by fifo_has_space for 10 cycles
        strobe_cyc.delete();
        fifo_has_space = 1'b0;
        issue_cmd(1'b0);
        c0 = 0;
        repeat (10) begin
            @(negedge tb_clk);
            if (row_ready || !busy) c0++;
        end
        check("space_hold_cycles_bad", c0, 0);
        for (int r = 0; r < N; r++) expect_row(1'b0, r, pat(16'h41 + r), pat(16'h51 + r));
        @(negedge tb_clk);
        fifo_has_space = 1'b1;
        c0 = cyc;
        send_row(pat(16'h41), pat(16'h51), 0);
        fifo_has_space = 1'b0;
        for (int r = 1; r < N; r++) send_row(pat(16'h41 + r), pat(16'h51 + r), 0);
        end_rows();
        repeat (6) @(negedge tb_clk);
        fifo_has_space = 1'b1;
        if (strobe_cyc.size() > 0) check("space_first_strobe_cycle", strobe_cyc[0], c0 + 3);
        check_diffs("space_job", 1'b0, 3, '{2, 2, 2, 0, 0, 0, 0, 0});
        check("space_job_queue_empty", exp_q.size(), 0);

        // Drain wait, drained dropping mid-burst, row 2 stalled 3 cycles
        strobe_cyc.delete();
        drained = 1'b0;
        issue_cmd(1'b1);
        c0 = 0;
        repeat (5) begin
            @(negedge tb_clk);
            if (row_ready || !busy) c0++;
        end
        check("drain_hold_cycles_bad", c0, 0);
        for (int r = 0; r < N; r++) expect_row(1'b1, r, pat(16'h61 + r), '0);
        for (int r = 0; r < N; r++) expect_row(1'b0, r, pat(16'h71 + r), pat(16'h81 + r));
        @(negedge tb_clk);
        drained = 1'b1;
        send_row(pat(16'h61), '0, 0);
        drained = 1'b0;
        send_row(pat(16'h62), '0, 0);
        send_row(pat(16'h63), '0, 3);
        send_row(pat(16'h64), '0, 0);
        for (int r = 0; r < N; r++) send_row(pat(16'h71 + r), pat(16'h81 + r), 0);
        end_rows();
        drained = 1'b1;
        repeat (6) @(negedge tb_clk);
        check_diffs("stall_job", 1'b0, 7, '{1, 4, 1, 1, 2, 2, 2, 0});
        check("stall_job_queue_empty", exp_q.size(), 0);

        // cmd_valid held high across a job: one acceptance per IDLE visit
        strobe_cyc.delete(); done_cyc.delete();
        acc_cnt = 0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < N; r++) expect_row(1'b0, r, pat(16'h91 + 8*k + r), pat(16'hA1 + 8*k + r));
        @(negedge tb_clk);
        cmd_valid = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < N; r++) send_row(pat(16'h91 + 8*k + r), pat(16'hA1 + 8*k + r), 0);
        cmd_valid = 1'b0;
        end_rows();
        repeat (6) @(negedge tb_clk);
        check("held_cmd_acceptances", acc_cnt, 2);
        check("held_cmd_done_count", done_cyc.size(), 2);
        check("held_cmd_strobe_count", strobe_cyc.size(), 8);
        check("held_cmd_queue_empty", exp_q.size(), 0);

        // Reset after input row 1, then a fresh job restarts at row 0
        strobe_cyc.delete();
        expect_row(1'b0, 0, pat(16'hC1), pat(16'hD1));
        expect_row(1'b0, 1, pat(16'hC2), pat(16'hD2));
        issue_cmd(1'b0);
        send_row(pat(16'hC1), pat(16'hD1), 0);
        send_row(pat(16'hC2), pat(16'hD2), 0);
        end_rows();
        repeat (3) @(negedge tb_clk);
        #2 nRST = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_outputs", {weight_en, input_en, partial_en, done, row_ready, row_in_en, array_in}, 256'd0);
        @(negedge tb_clk);
        nRST = 1'b1;
        @(negedge tb_clk);
        check("midreset_release", {cmd_ready, busy}, 2'b10);
        repeat (5) @(negedge tb_clk);
        check("midreset_strobe_count", strobe_cyc.size(), 2);
        check("midreset_queue_empty", exp_q.size(), 0);
        strobe_cyc.delete();
        for (int r = 0; r < N; r++) expect_row(1'b0, r, pat(16'hE1 + r), pat(16'hF1 + r));
        issue_cmd(1'b0);
        for (int r = 0; r < N; r++) send_row(pat(16'hE1 + r), pat(16'hF1 + r), 0);
        end_rows();
        repeat (6) @(negedge tb_clk);
        check_diffs("fresh_job", 1'b0, 3, '{2, 2, 2, 0, 0, 0, 0, 0});
        check("fresh_job_queue_empty", exp_q.size(), 0);

        // GAP_CYCLES=0: back-to-back input rows of 0x3C00 per lane
        begin
            exp_t e;
            for (int r = 0; r < N; r++) begin
                e.w = 1'b0; e.idx = IW'(r);
                e.d = {4{16'h3C00}}; e.p = {4{16'h4000}};
                exp0_q.push_back(e);
            end
        end
        @(negedge tb_clk);
        g0_row_data = {4{16'h3C00}}; g0_row_partial = {4{16'h4000}}; g0_row_valid = 1'b1;
        check("g0_cmd_ready", g0_cmd_ready, 1'b1);
        g0_cmd_valid = 1'b1;
        @(negedge tb_clk);
        g0_cmd_valid = 1'b0;
        repeat (10) @(negedge tb_clk);
        g0_row_valid = 1'b0;
        check_diffs("nogap_job", 1'b1, 3, '{1, 1, 1, 0, 0, 0, 0, 0});
        check("nogap_done_count", done0_cyc.size(), 1);
        if (done0_cyc.size() == 1 && strobe0_cyc.size() == 4)
            check("nogap_done_cycle", done0_cyc[0], strobe0_cyc[3] - 1);
        check("nogap_queue_empty", exp0_q.size(), 0);

        check("ready_while_busy", bad_rdy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
